// File: rtl/instruction_memory.sv
// Block-read instruction memory: fixed-latency 128-bit block returns to the
// instruction cache, with a byte-wide preload port that only writes while idle.

module instruction_memory_bank #(
  parameter int DEPTH = 64
) (
  input  logic       clock,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
  input  logic [5:0] raddr,
  output logic [7:0] rdata
);
  // No reset on storage so preloaded program bytes survive a reset.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module instruction_memory #(
  parameter int READ_CYCLES  = 4,
  parameter int DEPTH_BLOCKS = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [5:0]   address,
  output logic [127:0] readdata,
  output logic         busywait,
  input  logic         load_en,
  input  logic [9:0]   load_addr,
  input  logic [7:0]   load_data,
  output logic         load_rejected
);
  localparam int         NUM_LANES = 16;
  localparam logic [3:0] CNT_INIT  = 4'(READ_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                        state;
  logic [3:0]                    cnt;
  logic [5:0]                    addr_q;
  logic [NUM_LANES-1:0][7:0]     rd_lanes;
  logic                          wr_ok;

  if (READ_CYCLES < 1 || READ_CYCLES > 15) begin : g_bad_read_cycles
    $error("READ_CYCLES must be within 1..15");
  end

  // Preload lands only when the read path is quiet; a concurrent read wins.
  assign wr_ok = load_en && (state == IDLE) && !read;

  // One byte lane per bank; lane b feeds readdata[8b+7:8b].
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    instruction_memory_bank #(.DEPTH(DEPTH_BLOCKS)) u_bank (
      .clock (clock),
      .we    (wr_ok && (load_addr[3:0] == 4'(g))),
      .waddr (load_addr[9:4]),
      .wdata (load_data),
      .raddr (addr_q),
      .rdata (rd_lanes[g])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      readdata      <= '0;
      load_rejected <= 1'b0;
    end else begin
      load_rejected <= load_en && !wr_ok;
      case (state)
        IDLE: if (read) begin
          addr_q <= address;
          cnt    <= CNT_INIT;
          state  <= BUSY;
        end
        BUSY: if (cnt == 4'd0) begin
          readdata <= rd_lanes;
          state    <= DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        DONE: if (!read) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational so the cache sees a stall in the same cycle it raises read.
  assign busywait = ((state == IDLE) && read) || (state == BUSY);
endmodule

// File: tb/tb_instruction_memory.sv
// Drives two instances (READ_CYCLES 4 and 1) with shared stimulus and checks
// latency, data, load rejection and reset against a byte-level model.

module tb_instruction_memory;
  localparam int RC_A = 4;
  localparam int RC_B = 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [5:0]   address;
  logic         load_en;
  logic [9:0]   load_addr;
  logic [7:0]   load_data;
  logic [127:0] rd_a, rd_b;
  logic         bw_a, bw_b, lr_a, lr_b;

  always #5 clock = ~clock;

  instruction_memory #(.READ_CYCLES(RC_A), .DEPTH_BLOCKS(64)) dut_a (
    .clock(clock), .reset(reset), .read(read), .address(address),
    .readdata(rd_a), .busywait(bw_a), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .load_rejected(lr_a));

  instruction_memory #(.READ_CYCLES(RC_B), .DEPTH_BLOCKS(64)) dut_b (
    .clock(clock), .reset(reset), .read(read), .address(address),
    .readdata(rd_b), .busywait(bw_b), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .load_rejected(lr_b));

  typedef struct {
    logic [5:0] a;
    int         hold;
    int         chg_at;
    int         ld_at;
    logic [5:0] exp_blk;
  } vec_t;

  logic [7:0]   model [1024];
  logic [127:0] sb_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] block_of(input logic [5:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = model[{b, 4'(i)}];
    return r;
  endfunction

  task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clock); #1;
    load_en = 1'b0;
    model[a] = d;
  endtask

  task automatic do_read(input vec_t v);
    logic [127:0] exp, prev_a;
    int d_a, d_b;
    prev_a = rd_a;
    sb_q.push_back(block_of(v.exp_blk));
    read = 1'b1; address = v.a;
    if (v.ld_at == 0) begin load_en = 1'b1; load_addr = {v.a, 4'h3}; load_data = 8'hA5; end
    #1;
    chk("busy_same_cycle_a", 128'(bw_a), 128'(1));
    chk("busy_same_cycle_b", 128'(bw_b), 128'(1));
    d_a = -1; d_b = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (k == 0) chk("rd_hold_while_busy", rd_a, prev_a);
      if (k == v.ld_at) begin
        chk("ld_reject_a", 128'(lr_a), 128'(1));
        chk("ld_reject_b", 128'(lr_b), 128'(1));
        load_en = 1'b0;
      end
      if (v.ld_at >= 0 && k == v.ld_at + 1) chk("ld_reject_one_cycle", 128'(lr_a), 128'(0));
      if (k + 1 == v.ld_at) begin load_en = 1'b1; load_addr = {v.a, 4'h3}; load_data = 8'hA5; end
      if (k + 1 == v.chg_at) address = 6'd9;
      if (d_a < 0 && !bw_a) d_a = k;
      if (d_b < 0 && !bw_b) d_b = k;
      if (d_a >= 0 && d_b >= 0 && k > v.ld_at) break;
    end
    chk("latency_a", 128'(d_a), 128'(RC_A));
    chk("latency_b", 128'(d_b), 128'(RC_B));
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      exp = sb_q.pop_front();
      chk("data_a", rd_a, exp);
      chk("data_b", rd_b, exp);
      for (int h = 0; h < v.hold; h++) begin
        @(posedge clock); #1;
        chk("no_retrigger", 128'(bw_a | bw_b), 128'(0));
        chk("rd_stable_done", rd_a, exp);
      end
    end
    read = 1'b0;
    @(posedge clock); #1;
    chk("idle_after_drop", 128'(bw_a), 128'(0));
  endtask

  initial begin
    vec_t       tbl [8];
    logic [5:0] blks [4];
    tbl[0] = '{6'd5,  3, 0, -1, 6'd5};   // basic read, hold after DONE
    tbl[1] = '{6'd6,  0, 0, -1, 6'd6};   // immediately after one read=0 edge
    tbl[2] = '{6'd5,  0, 2, -1, 6'd5};   // address moves to 9 mid-transfer
    tbl[3] = '{6'd9,  0, 0,  2, 6'd9};   // load during BUSY
    tbl[4] = '{6'd9,  0, 0,  0, 6'd9};   // load on the accepting edge
    tbl[5] = '{6'd9,  1, 0, -1, 6'd9};   // block 9 untouched by rejected loads
    tbl[6] = '{6'd63, 0, 0, -1, 6'd63};
    tbl[7] = '{6'd0,  0, 0, -1, 6'd0};
    blks = '{6'd6, 6'd9, 6'd0, 6'd63};

    reset = 1'b0; read = 1'b0; address = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    #12;
    chk("reset_busywait", 128'(bw_a), 128'(0));
    chk("reset_readdata_a", rd_a, 128'(0));
    chk("reset_readdata_b", rd_b, 128'(0));
    chk("reset_load_rejected", 128'(lr_a), 128'(0));
    @(posedge clock); #1;
    reset = 1'b1;

    for (int i = 0; i < 16; i++) load_byte({6'd5, 4'(i)}, 8'(i));
    chk("load_accepted", 128'(lr_a), 128'(0));
    foreach (blks[j])
      for (int i = 0; i < 16; i++) load_byte({blks[j], 4'(i)}, 8'($urandom_range(0, 255)));

    for (int i = 0; i < 8; i++) begin
      do_read(tbl[i]);
      if (i == 0) chk("blk5_literal", rd_a, 128'h0F0E0D0C0B0A09080706050403020100);
    end

    // Reset two edges into a transfer, then confirm the array survived.
    read = 1'b1; address = 6'd5;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0; read = 1'b0;
    #1;
    chk("rst_abort_busywait", 128'(bw_a), 128'(0));
    chk("rst_abort_readdata_a", rd_a, 128'(0));
    chk("rst_abort_readdata_b", rd_b, 128'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("no_data_after_abort", rd_a, 128'(0));
    do_read('{6'd5, 0, 0, -1, 6'd5});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter READ_CYCLES, default 4, SHALL set the number of clock edges from request acceptance to data return; legal range 1..15.
REQ-002 Parameter DEPTH_BLOCKS, default 64, SHALL set the number of 128-bit blocks stored (16 bytes each, 1024 bytes total).
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 read  input  1  SHALL be the block-read request from the instruction cache, held high until the cache has taken the data.
REQ-006 address  input  6  SHALL be the block address (byte address bits [9:4]).
REQ-007 readdata  output  128  SHALL be the returned block.
REQ-008 busywait  output  1  SHALL be high while a requested block is not yet available.
REQ-009 load_en  input  1  SHALL be the byte-write strobe for program preload.
REQ-010 load_addr  input  10  SHALL be the byte address for preload.
REQ-011 load_data  input  8  SHALL be the preload byte.
REQ-012 load_rejected  output  1  SHALL pulse high for one cycle when a load_en is ignored.

Function
REQ-013 Storage SHALL be DEPTH_BLOCKS x 128 bits, byte-addressable for preload; byte b of block a SHALL map to readdata[8b+7:8b], b = 0..15.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE.
REQ-015 IDLE: on an edge with read=1, the block SHALL latch address, load the counter with READ_CYCLES-1, and move to BUSY.
REQ-016 BUSY: on each edge, if the counter is 0, the block SHALL load readdata from the latched block and move to DONE; otherwise it SHALL decrement the counter.
REQ-017 Total latency SHALL be READ_CYCLES edges from the accepting edge E0 to the edge that enters DONE.
REQ-018 DONE: the block SHALL hold readdata and keep busywait=0; it SHALL stay in DONE while read=1 and move to IDLE on the first edge with read=0.
REQ-019 busywait SHALL be combinational: 1 when (IDLE and read=1) or in BUSY, else 0, so that the cache sees busywait=1 in the same cycle it raises read.
REQ-020 Changes to address while in BUSY or DONE SHALL be ignored; the latched address governs.
REQ-021 A new read SHALL require read=0 on at least one edge after DONE; back-to-back reads therefore have a minimum spacing of READ_CYCLES+2 edges.
REQ-022 load_en SHALL write load_data to load_addr on an edge only in IDLE with read=0; otherwise the write SHALL be dropped and load_rejected SHALL pulse on that edge.
REQ-023 If read=1 and load_en=1 arrive on the same IDLE edge, the read SHALL win and the load SHALL be rejected.
REQ-024 readdata SHALL change only on entry to DONE or on reset.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, counter 0, latched address 0, readdata 0, busywait 0 (with read=0), and load_rejected 0.
REQ-026 Reset during BUSY or DONE SHALL abort the transfer with no data returned.
REQ-027 Reset SHALL NOT clear the storage array; preloaded contents SHALL survive reset.
REQ-028 After reset release, the first edge with read=1 SHALL be accepted as in REQ-015.

Verification
REQ-029 Preload block 5 with bytes 0x00..0x0F, then read=1, address=5, READ_CYCLES=4 -> busywait goes high in the same cycle; DONE is entered at E0+4 with readdata=0x0F0E...0100 and busywait=0.
REQ-030 Hold read=1 for 3 cycles after DONE, then drop it, then immediately request address=6 -> no retrigger while read is high; the new request is accepted only after one read=0 edge.
REQ-031 Change address from 5 to 9 at E0+2 -> block 5 is still returned.
REQ-032 Pulse load_en during BUSY, and also with read on the same IDLE edge -> the array is unchanged and load_rejected pulses once each time.
REQ-033 Assert reset=0 at E0+2 -> busywait and readdata go to 0 asynchronously; after release, re-reading block 5 returns the preloaded value.
REQ-034 Set READ_CYCLES=1 -> DONE is entered at E0+1.
